// File: rtl/cmd_pkg.sv
// Shared definitions for cmd_assembler: receive/transmit state encodings and
// the byte-slot positions inside the 24-bit command word.
package cmd_pkg;

    typedef enum logic [1:0] {BYTE_HI, BYTE_MID, BYTE_LO, FULL} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    localparam int HI  = 2;
    localparam int MID = 1;
    localparam int LO  = 0;

endpackage

// File: rtl/resp_sender.sv
// Single-byte response path: latches a byte on request, kicks the UART
// transmitter, and reports completion once the byte has gone out.
module resp_sender
    import cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_resp,
    input  logic [7:0] resp_data,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       resp_sent
);

    tx_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TX_IDLE;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            resp_sent <= 1'b0;
            case (state)
                TX_IDLE: if (send_resp) begin
                    tx_data  <= resp_data;
                    tx_start <= 1'b1;
                    state    <= TX_BUSY;
                end
                // requests arriving while busy are dropped; tx_data stays put
                TX_BUSY: if (tx_done) begin
                    resp_sent <= 1'b1;
                    state     <= TX_IDLE;
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmd_assembler.sv
// Assembles 3-byte UART commands (first byte in [23:16]) and forwards responses.
// Define CMD_TIMEOUT_EN to discard partial commands after TIMEOUT_CYCLES idle cycles.
module cmd_assembler
    import cmd_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        cmd_timeout
);

    rx_state_t rx_state;
    logic      accept;
    logic      expire;

    assign accept = rx_rdy && (rx_state != FULL);
    // Same-cycle acknowledge so the receiver drops rx_rdy before the next edge.
    assign clr_rx_rdy = rst_n && accept;
    assign cmd_rdy    = (rx_state == FULL);

`ifdef CMD_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 20'd2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 20'd1);

    logic [CW-1:0] idle_cnt;
    logic          waiting;

    assign waiting = ((rx_state == BYTE_MID) || (rx_state == BYTE_LO)) && !rx_rdy;
    assign expire  = waiting && (idle_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt    <= '0;
            cmd_timeout <= 1'b0;
        end else begin
            cmd_timeout <= expire;
            if (waiting && !expire)
                idle_cnt <= idle_cnt + 1'b1;
            else
                idle_cnt <= '0;
        end
    end
`else
    assign expire      = 1'b0;
    assign cmd_timeout = 1'b0;
`endif

    // cmd is deliberately left untouched on timeout; the next command overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= BYTE_HI;
            cmd      <= 24'h000000;
        end else begin
            case (rx_state)
                BYTE_HI: if (rx_rdy) begin
                    cmd[HI*8 +: 8] <= rx_data;
                    rx_state       <= BYTE_MID;
                end
                BYTE_MID: if (rx_rdy) begin
                    cmd[MID*8 +: 8] <= rx_data;
                    rx_state        <= BYTE_LO;
                end else if (expire) begin
                    rx_state <= BYTE_HI;
                end
                BYTE_LO: if (rx_rdy) begin
                    cmd[LO*8 +: 8] <= rx_data;
                    rx_state       <= FULL;
                end else if (expire) begin
                    rx_state <= BYTE_HI;
                end
                FULL: if (clr_cmd_rdy) rx_state <= BYTE_HI;
                default: rx_state <= BYTE_HI;
            endcase
        end
    end

    resp_sender u_resp_sender (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_resp (send_resp),
        .resp_data (resp_data),
        .tx_done   (tx_done),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .resp_sent (resp_sent)
    );

endmodule
